// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared defaults for the multi-port register file and the helper used to
// size the packed per-port buses (port k of a bus occupies [k*w +: w]).
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEF_BW_DATA = 16;
    localparam int DEF_BW_ADDR = 4;
    localparam int DEF_N_WR    = 2;
    localparam int DEF_N_RD    = 3;

    // Width of a packed bus carrying n ports of w bits each.
    function automatic int slice_w(input int n, input int w);
        return n * w;
    endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// ----------------------------------------------------------------------------
// regfile_wr_arb
// Resolves all write ports down to one write per entry. When several enabled
// ports target the same entry, the highest-index port wins and a conflict is
// flagged. With ZERO_REG set, entry 0 is never written and never conflicts.
//
// Ports:
//   wr_en      per-port write enable
//   wr_addr    packed write addresses, port k at [k*BW_ADDR +: BW_ADDR]
//   wr_data    packed write data, port k at [k*BW_DATA +: BW_DATA]
//   ent_we     per-entry resolved write enable
//   ent_wdata  per-entry resolved (winning) write data
//   conflict   combinational: two or more enabled writes share an entry
// ----------------------------------------------------------------------------
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int BW_DATA  = DEF_BW_DATA,
    parameter int BW_ADDR  = DEF_BW_ADDR,
    parameter int N_WR     = DEF_N_WR,
    parameter int ZERO_REG = 0,
    localparam int DEPTH   = 1 << BW_ADDR
) (
    input  logic [N_WR-1:0]                     wr_en,
    input  logic [slice_w(N_WR, BW_ADDR)-1:0]   wr_addr,
    input  logic [slice_w(N_WR, BW_DATA)-1:0]   wr_data,
    output logic [DEPTH-1:0]                    ent_we,
    output logic [BW_DATA-1:0]                  ent_wdata [DEPTH],
    output logic                                conflict
);

    // Ports are scanned in ascending order so a later (higher-index) hit
    // overwrites an earlier one; a hit on an already-claimed entry is a
    // conflict.
    always_comb begin
        ent_we   = '0;
        conflict = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            ent_wdata[e] = '0;
        end
        for (int e = 0; e < DEPTH; e++) begin
            for (int k = 0; k < N_WR; k++) begin
                if (wr_en[k] &&
                    (wr_addr[k*BW_ADDR +: BW_ADDR] == BW_ADDR'(e)) &&
                    !((ZERO_REG != 0) && (e == 0))) begin
                    if (ent_we[e]) begin
                        conflict = 1'b1;
                    end
                    ent_we[e]    = 1'b1;
                    ent_wdata[e] = wr_data[k*BW_DATA +: BW_DATA];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// ----------------------------------------------------------------------------
// regfile_mp
// Multi-port register file: N_WR write ports, N_RD read ports, optional
// registered read, optional write-to-read bypass, optional hard-zero entry 0.
//
// Ports:
//   i_clk             clock, rising edge
//   i_rstn            asynchronous active-low reset
//   i_rf_clr          synchronous clear of all entries (beats any write)
//   i_rf_wr_en        per-port write enable
//   i_rf_wr_addr      packed write addresses
//   i_rf_wr_data      packed write data
//   i_rf_rd_en        per-port read enable
//   i_rf_rd_addr      packed read addresses
//   o_rf_rd_data      packed read data
//   o_rf_rd_vld       per-port read valid
//   o_rf_wr_conflict  registered: previous cycle had colliding writes
// ----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int BW_DATA  = DEF_BW_DATA,
    parameter int BW_ADDR  = DEF_BW_ADDR,
    parameter int N_WR     = DEF_N_WR,
    parameter int N_RD     = DEF_N_RD,
    parameter int RD_REG   = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                                i_clk,
    input  logic                                i_rstn,
    input  logic                                i_rf_clr,
    input  logic [N_WR-1:0]                     i_rf_wr_en,
    input  logic [slice_w(N_WR, BW_ADDR)-1:0]   i_rf_wr_addr,
    input  logic [slice_w(N_WR, BW_DATA)-1:0]   i_rf_wr_data,
    input  logic [N_RD-1:0]                     i_rf_rd_en,
    input  logic [slice_w(N_RD, BW_ADDR)-1:0]   i_rf_rd_addr,
    output logic [slice_w(N_RD, BW_DATA)-1:0]   o_rf_rd_data,
    output logic [N_RD-1:0]                     o_rf_rd_vld,
    output logic                                o_rf_wr_conflict
);

    localparam int DEPTH = 1 << BW_ADDR;

    logic [BW_DATA-1:0] mem [DEPTH];
    logic [DEPTH-1:0]   ent_we;
    logic [BW_DATA-1:0] ent_wdata [DEPTH];
    logic               conflict;

    // Single arbiter feeds both the storage update and the bypass muxes so
    // the two can never disagree on which port won.
    regfile_wr_arb #(
        .BW_DATA  (BW_DATA),
        .BW_ADDR  (BW_ADDR),
        .N_WR     (N_WR),
        .ZERO_REG (ZERO_REG)
    ) u_wr_arb (
        .wr_en     (i_rf_wr_en),
        .wr_addr   (i_rf_wr_addr),
        .wr_data   (i_rf_wr_data),
        .ent_we    (ent_we),
        .ent_wdata (ent_wdata),
        .conflict  (conflict)
    );

    // Storage: clear wins over every write in the same cycle.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem[e] <= '0;
            end
        end else if (i_rf_clr) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (ent_we[e]) begin
                    mem[e] <= ent_wdata[e];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_rf_wr_conflict <= 1'b0;
        end else begin
            o_rf_wr_conflict <= conflict;
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [BW_ADDR-1:0] rd_addr;
        logic [BW_DATA-1:0] rd_val;

        assign rd_addr = i_rf_rd_addr[k*BW_ADDR +: BW_ADDR];

        // Bypassed data follows the arbiter winner, but a concurrent clear
        // means the entry ends the cycle as zero, so forward zero instead.
        always_comb begin
            rd_val = mem[rd_addr];
            if ((ZERO_REG != 0) && (rd_addr == '0)) begin
                rd_val = '0;
            end else if ((BYPASS != 0) && ent_we[rd_addr]) begin
                rd_val = i_rf_clr ? '0 : ent_wdata[rd_addr];
            end
        end

        if (RD_REG != 0) begin : g_reg
            logic [BW_DATA-1:0] rd_data_q;
            logic               rd_vld_q;

            // Data holds when the port is idle; valid is a one-cycle echo.
            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    rd_data_q <= '0;
                    rd_vld_q  <= 1'b0;
                end else begin
                    rd_vld_q <= i_rf_rd_en[k];
                    if (i_rf_rd_en[k]) begin
                        rd_data_q <= rd_val;
                    end
                end
            end

            assign o_rf_rd_data[k*BW_DATA +: BW_DATA] = rd_data_q;
            assign o_rf_rd_vld[k]                     = rd_vld_q;
        end else begin : g_comb
            assign o_rf_rd_data[k*BW_DATA +: BW_DATA] = rd_val;
            assign o_rf_rd_vld[k]                     = i_rf_rd_en[k];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// ----------------------------------------------------------------------------
// tb_regfile_mp
// Drives three regfile_mp variants with identical stimulus:
//   v0: RD_REG=1 BYPASS=1 ZERO_REG=0
//   v1: RD_REG=1 BYPASS=0 ZERO_REG=0
//   v2: RD_REG=1 BYPASS=1 ZERO_REG=1
// and compares every output against a behavioural array model.
// ----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int NV = 3;

    logic        clk;
    logic        rst_n;
    logic        rf_clr;
    logic [1:0]  wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  rd_en;
    logic [11:0] rd_addr;

    logic [47:0] rd_data_v [NV];
    logic [2:0]  rd_vld_v  [NV];
    logic        conf_v    [NV];

    logic [15:0] m_mem  [NV][16];
    logic [15:0] m_rd   [NV][3];
    logic [2:0]  m_vld  [NV];
    logic        m_conf [NV];

    int n_checks = 0;
    int n_pass   = 0;

    regfile_mp #(.RD_REG(1), .BYPASS(1), .ZERO_REG(0)) dut_byp (
        .i_clk(clk), .i_rstn(rst_n), .i_rf_clr(rf_clr),
        .i_rf_wr_en(wr_en), .i_rf_wr_addr(wr_addr), .i_rf_wr_data(wr_data),
        .i_rf_rd_en(rd_en), .i_rf_rd_addr(rd_addr),
        .o_rf_rd_data(rd_data_v[0]), .o_rf_rd_vld(rd_vld_v[0]),
        .o_rf_wr_conflict(conf_v[0])
    );

    regfile_mp #(.RD_REG(1), .BYPASS(0), .ZERO_REG(0)) dut_nobyp (
        .i_clk(clk), .i_rstn(rst_n), .i_rf_clr(rf_clr),
        .i_rf_wr_en(wr_en), .i_rf_wr_addr(wr_addr), .i_rf_wr_data(wr_data),
        .i_rf_rd_en(rd_en), .i_rf_rd_addr(rd_addr),
        .o_rf_rd_data(rd_data_v[1]), .o_rf_rd_vld(rd_vld_v[1]),
        .o_rf_wr_conflict(conf_v[1])
    );

    regfile_mp #(.RD_REG(1), .BYPASS(1), .ZERO_REG(1)) dut_zero (
        .i_clk(clk), .i_rstn(rst_n), .i_rf_clr(rf_clr),
        .i_rf_wr_en(wr_en), .i_rf_wr_addr(wr_addr), .i_rf_wr_data(wr_data),
        .i_rf_rd_en(rd_en), .i_rf_rd_addr(rd_addr),
        .o_rf_rd_data(rd_data_v[2]), .o_rf_rd_vld(rd_vld_v[2]),
        .o_rf_wr_conflict(conf_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit has_bypass(input int v);
        return (v != 1);
    endfunction

    function automatic bit has_zero(input int v);
        return (v == 2);
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            for (int a = 0; a < 16; a++) m_mem[v][a] = '0;
            for (int k = 0; k < 3; k++) m_rd[v][k] = '0;
            m_vld[v]  = '0;
            m_conf[v] = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int v = 0; v < NV; v++) begin
            for (int k = 0; k < 3; k++) begin
                check_output($sformatf("v%0d_rd%0d_data", v, k),
                             64'(rd_data_v[v][k*16 +: 16]), 64'(m_rd[v][k]));
            end
            check_output($sformatf("v%0d_vld", v), 64'(rd_vld_v[v]), 64'(m_vld[v]));
            check_output($sformatf("v%0d_conflict", v), 64'(conf_v[v]), 64'(m_conf[v]));
        end
    endtask

    // One clock of stimulus: drive inputs, advance the model across the
    // edge, then compare all outputs just after the edge.
    task automatic apply_stimulus(input logic clr, input logic [1:0] we, input logic [7:0] wa,
                                  input logic [31:0] wd, input logic [2:0] re, input logic [11:0] ra);
        int hits [16];
        int last [16];
        logic [3:0] a;
        rf_clr  = clr;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < 16; i++) begin
                hits[i] = 0;
                last[i] = 0;
            end
            for (int p = 0; p < 2; p++) begin
                if (we[p]) begin
                    a = wa[p*4 +: 4];
                    if (!(has_zero(v) && a == 4'd0)) begin
                        hits[a]++;
                        last[a] = p;
                    end
                end
            end
            m_conf[v] = 1'b0;
            for (int i = 0; i < 16; i++) begin
                if (hits[i] >= 2) m_conf[v] = 1'b1;
            end
            m_vld[v] = re;
            for (int k = 0; k < 3; k++) begin
                if (re[k]) begin
                    a = ra[k*4 +: 4];
                    if (has_zero(v) && a == 4'd0)
                        m_rd[v][k] = '0;
                    else if (has_bypass(v) && hits[a] > 0)
                        m_rd[v][k] = clr ? 16'h0 : wd[last[a]*16 +: 16];
                    else
                        m_rd[v][k] = m_mem[v][a];
                end
            end
            for (int i = 0; i < 16; i++) begin
                if (clr) m_mem[v][i] = '0;
                else if (hits[i] > 0) m_mem[v][i] = wd[last[i]*16 +: 16];
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic random_cycle(input bit allow_clr);
        logic [7:0] wa;
        for (int p = 0; p < 2; p++) begin
            wa[p*4 +: 4] = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3))
                                                       : 4'($urandom_range(0, 15));
        end
        apply_stimulus(allow_clr && ($urandom_range(0, 19) == 0),
                       2'($urandom_range(0, 3)), wa, $urandom,
                       3'($urandom_range(0, 7)), 12'($urandom));
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) begin
            apply_stimulus(1'b0, 2'b00, 8'h00, 32'h0, 3'b111, {3{4'(a)}});
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        rf_clr  = 1'b0;
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = '0;
        rd_addr = '0;
        model_reset();
        #1;
        check_all();
        #11;
        rst_n = 1'b1;

        $display("[TB] reset then read all entries on all ports");
        read_all();
        check_output("post_reset_vld", 64'(rd_vld_v[0]), 64'h7);

        $display("[TB] same-cycle write bypass on read port 2");
        apply_stimulus(1'b0, 2'b01, 8'h03, 32'h0000_00A5, 3'b100, 12'h300);
        check_output("bypass_on", 64'(rd_data_v[0][47:32]), 64'h00A5);
        check_output("bypass_off", 64'(rd_data_v[1][47:32]), 64'h0000);

        $display("[TB] colliding writes to one address");
        apply_stimulus(1'b0, 2'b11, 8'h55, 32'hBEEF_1234, 3'b000, 12'h000);
        check_output("conflict_set", 64'(conf_v[0]), 64'h1);
        apply_stimulus(1'b0, 2'b00, 8'h00, 32'h0, 3'b001, 12'h005);
        check_output("conflict_win", 64'(rd_data_v[0][15:0]), 64'hBEEF);
        check_output("conflict_drop", 64'(conf_v[0]), 64'h0);

        $display("[TB] writes to entry 0");
        apply_stimulus(1'b0, 2'b11, 8'h00, 32'hFFFF_FFFF, 3'b001, 12'h000);
        check_output("zero_byp_rd", 64'(rd_data_v[2][15:0]), 64'h0);
        apply_stimulus(1'b0, 2'b00, 8'h00, 32'h0, 3'b111, 12'h000);
        check_output("zero_rd", 64'(rd_data_v[2]), 64'h0);
        check_output("zero_conflict", 64'(conf_v[2]), 64'h0);

        $display("[TB] random traffic");
        for (int i = 0; i < 150; i++) random_cycle(1'b1);

        $display("[TB] fill, then clear racing a write");
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b0, 2'b01, {4'h0, 4'(i)}, {16'h0, 16'(1 << i)}, 3'b000, 12'h000);
        end
        apply_stimulus(1'b0, 2'b00, 8'h00, 32'h0, 3'b001, 12'h009);
        check_output("fill_rd9", 64'(rd_data_v[0][15:0]), 64'h0200);
        apply_stimulus(1'b1, 2'b01, 8'h07, 32'h0000_7777, 3'b000, 12'h000);
        read_all();
        check_output("clr_rd15", 64'(rd_data_v[0]), 64'h0);

        for (int i = 0; i < 100; i++) random_cycle(1'b0);

        $display("[TB] asynchronous reset during a write burst");
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 2'b11, 8'($urandom), $urandom, 3'b111, 12'($urandom));
        end
        wr_en   = 2'b11;
        wr_addr = 8'($urandom);
        wr_data = $urandom;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        #2;
        rst_n = 1'b1;
        read_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
